// File: rtl/nnaccel_pkg.sv
// nnaccel_pkg: shared FSM state enum, frame defaults and a
// constant clog2 helper for the image frame loader.
package nnaccel_pkg;

  localparam int IMG_PIXELS_DEF = 196;
  localparam int CHUNK_W_DEF    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } ifl_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/frame_bit_ram.sv
// frame_bit_ram: DEPTH x 1-bit register array, WR_W-bit masked
// write starting at wr_base, 1-bit registered read (0 if out of range).
// Ports: clk, rst (sync, clears read register only), we, wr_base,
//   wr_data, wr_mask, rd_addr, rd_data.
module frame_bit_ram
  import nnaccel_pkg::*;
#(
  parameter int DEPTH  = 196,
  parameter int WR_W   = 7,
  parameter int ADDR_W = 8,
  parameter int PTR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_base,
  input  logic [WR_W-1:0]   wr_data,
  input  logic [WR_W-1:0]   wr_mask,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  logic [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0] wen;
  logic [DEPTH-1:0] wval;
  logic             rd_q;

  // Per-pixel enable decode keeps every register index constant.
  always_comb begin
    wen  = '0;
    wval = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < WR_W; k++) begin
        if (int'(wr_base) + k == i) begin
          wen[i]  = we & wr_mask[k];
          wval[i] = wr_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wen[i]) mem_q[i] <= wval[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b0;
    end else if (int'(rd_addr) < DEPTH) begin
      rd_q <= mem_q[rd_addr];
    end else begin
      rd_q <= 1'b0;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/image_frame_loader.sv
// image_frame_loader: captures a 1-bit image in CHUNK_W-pixel beats,
// holds it for registered random readout until consumed.
// Ports: clk, rst, start, in_valid/in_ready/in_data, frame_done,
//   frame_valid, rd_addr/rd_data, consume, beat_cnt.
// Option IMAGE_FRAME_LOADER_POPCOUNT_EN adds pix_count (ones written).
module image_frame_loader
  import nnaccel_pkg::*;
#(
  parameter int IMG_PIXELS = IMG_PIXELS_DEF,
  parameter int CHUNK_W    = CHUNK_W_DEF,
  localparam int ADDR_W    = clog2(IMG_PIXELS),
  localparam int BEATS     = (IMG_PIXELS + CHUNK_W - 1) / CHUNK_W,
  localparam int BCNT_W    = clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  output logic              frame_done,
  output logic              frame_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data,
  input  logic              consume,
  output logic [BCNT_W-1:0] beat_cnt
`ifdef IMAGE_FRAME_LOADER_POPCOUNT_EN
  ,
  output logic [ADDR_W:0]   pix_count
`endif
);

  localparam int PTR_W = clog2(IMG_PIXELS + CHUNK_W);

  ifl_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              done_q, done_d;
  logic              we;
  logic              last;
  logic [CHUNK_W-1:0] wr_mask;

  // Lanes past the frame end in the final beat are dropped.
  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < CHUNK_W; k++) begin
      wr_mask[k] = (int'(wr_ptr_q) + k < IMG_PIXELS);
    end
  end

  assign last = (int'(wr_ptr_q) + CHUNK_W >= IMG_PIXELS);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    bcnt_d   = bcnt_q;
    done_d   = 1'b0;
    we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          bcnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          // restart wins over any beat offered this cycle
          wr_ptr_d = '0;
          bcnt_d   = '0;
        end else if (in_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(CHUNK_W);
          bcnt_d   = bcnt_q + BCNT_W'(1);
          if (last) begin
            state_d = ST_FULL;
            done_d  = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (consume) begin
          if (start) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            bcnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      bcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      bcnt_q   <= bcnt_d;
      done_q   <= done_d;
    end
  end

  assign in_ready    = (state_q == ST_LOAD);
  assign frame_valid = (state_q == ST_FULL);
  assign frame_done  = done_q;
  assign beat_cnt    = bcnt_q;

  frame_bit_ram #(
    .DEPTH  (IMG_PIXELS),
    .WR_W   (CHUNK_W),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_base (wr_ptr_q),
    .wr_data (in_data),
    .wr_mask (wr_mask),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef IMAGE_FRAME_LOADER_POPCOUNT_EN
  logic [ADDR_W:0] pix_q, pix_d, beat_ones;
  logic            clr;

  // Same cases that zero the counters above.
  assign clr = start && ((state_q != ST_FULL) || consume);

  always_comb begin
    beat_ones = '0;
    for (int k = 0; k < CHUNK_W; k++) begin
      beat_ones = beat_ones + (ADDR_W+1)'(in_data[k] & wr_mask[k]);
    end
  end

  always_comb begin
    pix_d = pix_q;
    if (clr) begin
      pix_d = '0;
    end else if (we) begin
      pix_d = pix_q + beat_ones;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pix_q <= '0;
    else     pix_q <= pix_d;
  end

  assign pix_count = pix_q;
`endif

endmodule

// File: doc/image_frame_loader.md
IMAGE_FRAME_LOADER -- requirements
Module: image_frame_loader

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 196, total 1-bit pixels per frame (14x14).
REQ-002 SHALL have parameter CHUNK_W, default 7, pixels delivered per input beat (1..16).
REQ-003 SHALL have derived constant ADDR_W = clog2(IMG_PIXELS) and BEATS = ceil(IMG_PIXELS/CHUNK_W).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  begin (or restart) frame capture.
REQ-007 SHALL have port in_valid  in  1  input beat valid.
REQ-008 SHALL have port in_ready  out  1  loader accepts a beat this cycle.
REQ-009 SHALL have port in_data  in  CHUNK_W  pixels; bit k maps to pixel wr_ptr+k.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse when the frame completes.
REQ-011 SHALL have port frame_valid  out  1  complete frame held, read port valid.
REQ-012 SHALL have port rd_addr  in  ADDR_W  pixel index for readout.
REQ-013 SHALL have port rd_data  out  1  registered pixel at rd_addr, 1-cycle latency.
REQ-014 SHALL have port consume  in  1  downstream releases the held frame.
REQ-015 SHALL have port beat_cnt  out  clog2(BEATS+1)  beats accepted in current frame.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FULL.
REQ-017 IDLE: in_ready=0; start -> LOAD with wr_ptr=0, beat_cnt=0.
REQ-018 LOAD: in_ready=1; beat accepted when in_valid&in_ready; writes CHUNK_W pixels at wr_ptr, wr_ptr+=CHUNK_W, beat_cnt+=1.
REQ-019 Pixels whose index >= IMG_PIXELS in the final beat SHALL be discarded, never written.
REQ-020 Accepted beat with wr_ptr+CHUNK_W >= IMG_PIXELS SHALL move LOAD -> FULL; frame_done pulses in the cycle FULL is entered (1 cycle after the accepting edge).
REQ-021 FULL: in_ready=0, frame_valid=1; in_valid ignored; memory not written.
REQ-022 start in LOAD SHALL restart: wr_ptr=0, beat_cnt=0, any same-cycle beat discarded; start has priority over a completing beat.
REQ-023 start in FULL without consume SHALL be ignored.
REQ-024 consume in FULL SHALL drop frame_valid next cycle and go IDLE; consume and start together SHALL go directly to LOAD with counters cleared.
REQ-025 consume outside FULL SHALL be ignored.
REQ-026 rd_data SHALL reflect pixel rd_addr sampled at previous edge; rd_addr >= IMG_PIXELS returns 0; content undefined-but-stable while not frame_valid.
REQ-027 Memory contents SHALL persist across restarts; only written pixels change.

Reset
REQ-028 rst SHALL force IDLE, wr_ptr=0, beat_cnt=0, in_ready=0, frame_valid=0, frame_done=0, rd_data=0.
REQ-029 rst SHALL override all other inputs same cycle, including mid-LOAD; pixel memory need not be cleared.

Configuration
REQ-030 With macro IMAGE_FRAME_LOADER_POPCOUNT_EN defined, SHALL add output pix_count (ADDR_W+1 bits) = number of 1 pixels written this frame, cleared on start/rst, updated same edge as write, stable in FULL.
REQ-031 Without IMAGE_FRAME_LOADER_POPCOUNT_EN, pix_count port and adder tree SHALL be absent; all other behaviour identical.

Structure
REQ-032 SHALL place FSM state enum, IMG_PIXELS/CHUNK_W defaults and clog2 helper in shared package nnaccel_pkg.
REQ-033 SHALL use one sub-module, frame_bit_ram: 1-bit-read, CHUNK_W-bit masked-write register array with registered read.

Verification
REQ-034 Defaults, start, 28 beats each 7'b1010101 -> frame_done pulse 1 cycle after 28th accept, frame_valid=1, rd_addr 0/1/195 -> 1/0/1.
REQ-035 CHUNK_W=8, 25 beats 8'hFF -> FULL after 25th beat, beat_cnt=25, rd_addr 195 -> 1, pixels 196..199 unwritten (no out-of-range write).
REQ-036 Start at beat 10, then 28 beats of 0 -> beat_cnt restarts at 0, all 196 pixels read 0, one frame_done only.
REQ-037 In FULL drive in_valid=1 with 7'h7F for 5 cycles -> in_ready=0, readback unchanged; consume+start same cycle -> LOAD next cycle, frame_valid=0.
REQ-038 rst asserted at beat 14 -> next cycle IDLE, all outputs 0; start and 28 beats -> normal completion.
REQ-039 POPCOUNT_EN, 28 beats 7'b0000111 -> pix_count=84 in FULL; start -> pix_count=0.
